// File: rtl/p2s_pkg.sv
// Shared types and elaboration-time helpers for the p2s_tx transmitter.
package p2s_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int frame_len(input int width, input int parity);
    return width + ((parity != 0) ? 1 : 0);
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter with valid/ready on both sides.
// Optional even-parity beat appended after the data bits when P2S_PARITY_EN is defined.
//
// state | meaning
// IDLE  | no frame in flight, in_ready=1, ser_valid=0
// SHIFT | presenting bit cnt_q of the current frame on ser_out
module p2s_tx
  import p2s_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_valid,
  output logic             ser_out,
  output logic             ser_first,
  output logic             ser_last,
  input  logic             ser_ready
);

`ifdef P2S_PARITY_EN
  localparam int PARITY_EN = 1;
`else
  localparam int PARITY_EN = 0;
`endif
  localparam int FRAME_LEN = frame_len(WIDTH, PARITY_EN);
  localparam int CNT_W     = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_e               state_q, state_d;
  logic [FRAME_LEN-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ser_valid_q, ser_valid_d;
  logic                 ser_first_q, ser_first_d;
  logic                 ser_last_q, ser_last_d;
  logic [FRAME_LEN-1:0] load_word;
  logic [FRAME_LEN-1:0] shifted;
  logic                 accept;
  logic                 beat;

  // Parity sits at the tail of the frame in either bit order.
  always_comb begin
`ifdef P2S_PARITY_EN
    if (LSB_FIRST != 0) load_word = {^in_data, in_data};
    else                load_word = {in_data, ^in_data};
`else
    load_word = in_data;
`endif
  end

  always_comb begin
    if (LSB_FIRST != 0) shifted = {1'b0, shreg_q[FRAME_LEN-1:1]};
    else                shifted = {shreg_q[FRAME_LEN-2:0], 1'b0};
  end

  assign in_ready = (state_q == IDLE) || ((state_q == SHIFT) && ser_last_q && ser_ready);
  assign accept   = in_valid && in_ready;
  assign beat     = (state_q == SHIFT) && ser_ready;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    ser_valid_d = ser_valid_q;
    ser_first_d = ser_first_q;
    ser_last_d  = ser_last_q;
    if (accept) begin
      // Covers both the idle load and the reload on the final beat.
      state_d     = SHIFT;
      shreg_d     = load_word;
      cnt_d       = '0;
      ser_valid_d = 1'b1;
      ser_first_d = 1'b1;
      ser_last_d  = 1'b0;
    end else if (beat) begin
      shreg_d     = shifted;
      ser_first_d = 1'b0;
      if (ser_last_q) begin
        state_d     = IDLE;
        ser_valid_d = 1'b0;
        ser_last_d  = 1'b0;
      end else begin
        cnt_d      = cnt_q + CNT_W'(1);
        ser_last_d = ((cnt_q + CNT_W'(1)) == LAST_CNT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      ser_valid_q <= ser_valid_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
    end
  end

  assign ser_valid = ser_valid_q;
  assign ser_first = ser_first_q;
  assign ser_last  = ser_last_q;
  assign ser_out   = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[FRAME_LEN-1];

endmodule
